cpu_ctrl: RTL
=============

Name: cpu_ctrl

Overview:
Multi-cycle control unit for the lab CPU. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the ALU's enable and operation code, the PC, IR and register-file write strobes, and the instruction/data memory request handshakes. Sits beside the datapath (PC, IR, register file, ALU, memory interfaces) in the CPU top level.

Parameters:
IMEM_WAIT_MAX, 15, max cycles in IF waiting for imem_ack before the fetch is aborted and a fault is flagged
DMEM_WAIT_MAX, 15, same limit for MEM waiting on dmem_ack

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  level; leave IDLE and begin fetching while high
instr  in  32  instruction word from the instruction memory, valid on the imem_ack cycle
alu_wen  in  1  the ALU's register-write qualifier (deasserted for MOVZ with rt!=0)
imem_req  out  1  instruction fetch request at address PC
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1 = store (SW), 0 = load (LW); valid while dmem_req is high
dmem_ack  in  1  data access complete
ir_we  out  1  latch instr into the IR
pc_we  out  1  update the PC
pc_sel  out  2  00 = PC+4, 01 = jump target {PC[31:28], IR[25:0], 2'b00}
alu_en  out  1  ALU enable
alu_card  out  5  ALU op code (shared macro codes)
alu_src_imm  out  1  ALU B operand = sign-extended IR[15:0]
rf_we  out  1  register-file write strobe
rf_wsel  out  1  write address: 0 = rd, 1 = rt
rf_wdata_sel  out  1  write data: 0 = ALU result, 1 = memory read data
fault  out  1  sticky; illegal opcode or handshake timeout
state_dbg  out  3  current state encoding
retired  out  32  count of instructions completed

Behaviour:
- Reset (async, resetn=0): state IDLE; every output 0, including retired and fault. Any outstanding imem_req or dmem_req drops combinationally with reset. A request that is later acked after reset is ignored.
- States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- IDLE: go to IF when start=1. If start is low when the controller re-enters IF from WB or ID, it goes to IDLE instead.
- IF: imem_req=1. On imem_ack: ir_we=1 and pc_we=1 with pc_sel=00 for one cycle, then go to ID. The wait counter is cleared on entry; if it exceeds IMEM_WAIT_MAX, set fault and go to HALT.
- ID: decode the IR.
  - op=000000 (R-type), func: 100000 ADD, 100010 ASUBB, 100100 AND, 100101 OR, 100110 XOR, 001010 MOVZ, 000000 SIL, 101010 CMP. Go to EX.
  - op=100011 LW, op=101011 SW: card ADD, alu_src_imm=1. Go to EX.
  - op=000010 J: pc_we=1, pc_sel=01, retired+1. Go to IF (or IDLE if start=0).
  - Any other op or func: set fault, go to HALT.
- EX: alu_en=1 with the decoded card. alu_en and alu_card stay registered-stable through EX, MEM and WB. R-type goes to WB; LW/SW go to MEM.
- MEM: dmem_req=1 and dmem_we=(SW). On dmem_ack: SW goes to IF with retired+1; LW goes to WB. Timeout handling is as in IF, using DMEM_WAIT_MAX.
- WB: rf_we for one cycle.
  - R-type: rf_we = alu_wen, rf_wsel=0, rf_wdata_sel=0.
  - LW: rf_we=1, rf_wsel=1, rf_wdata_sel=1.
  - retired+1, then go to IF (or IDLE if start=0).
- HALT: all strobes 0, fault=1. Exit only via reset.
- Strobes: ir_we, pc_we and rf_we are single-cycle pulses and never assert simultaneously with one another except ir_we+pc_we in IF. A request stays high until its ack; an ack arriving while no request is pending is ignored.
- retired wraps from 0xFFFFFFFF to 0.
- Same-cycle ack and timeout: the ack wins.

Decomposition:
- Shared macro.vh: ALU card codes (ADD, ASUBB, AND, OR, XOR, MOVZ, SIL, CMP), opcode/func constants, state encodings, pc_sel codes.
- One sub-module, cpu_decode: purely combinational IR → {card, class (R/LW/SW/J/illegal), src_imm}.
- cpu_ctrl holds the FSM, wait counters and the retired counter.

Test Plan:
- Reset, start=1, imem_ack after 2 cycles with instr=0x00221820 (ADD $3,$1,$2) → IF(3 cycles)→ID→EX(alu_card=ADD)→WB with rf_we=1, rf_wsel=0; retired=1.
- instr=0x8C220004 (LW) with dmem_ack on the 3rd MEM cycle → dmem_we=0, alu_src_imm=1, WB with rf_wsel=1 and rf_wdata_sel=1; SW 0xAC220004 → dmem_we=1, no WB, retired increments at the ack.
- MOVZ with alu_wen=0 → WB has rf_we=0, retired still +1; J 0x08000010 → pc_we with pc_sel=01 in ID, next state IF.
- instr=0xFC000000 → fault=1, state HALT, no strobes thereafter; imem_ack held low for 16 cycles → fault, HALT.
- resetn pulled low during MEM with dmem_req=1 → dmem_req drops in the same cycle, all outputs 0; a late dmem_ack is ignored; start=0 after WB → IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the lab CPU control path: FSM states, ALU card codes,
// opcode/function fields, instruction classes and PC-select codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    typedef enum logic [4:0] {
        CARD_NONE  = 5'd0,
        CARD_ADD   = 5'd1,
        CARD_ASUBB = 5'd2,
        CARD_AND   = 5'd3,
        CARD_OR    = 5'd4,
        CARD_XOR   = 5'd5,
        CARD_MOVZ  = 5'd6,
        CARD_SIL   = 5'd7,
        CARD_CMP   = 5'd8
    } card_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_J   = 3'd3,
        CLS_ILL = 3'd4
    } iclass_t;

    typedef struct packed {
        card_t   card;
        iclass_t iclass;
        logic    src_imm;
    } decode_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ASUBB = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_MOVZ  = 6'b001010;
    localparam logic [5:0] FN_SIL   = 6'b000000;
    localparam logic [5:0] FN_CMP   = 6'b101010;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP = 2'b01;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: opcode/function fields to ALU card,
// instruction class and immediate-operand select.
module cpu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output decode_t    dec
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        dec = '{card: CARD_NONE, iclass: CLS_ILL, src_imm: 1'b0};
        case (op)
            OP_RTYPE: begin
                dec.iclass = CLS_R;
                case (funct)
                    FN_ADD:   dec.card = CARD_ADD;
                    FN_ASUBB: dec.card = CARD_ASUBB;
                    FN_AND:   dec.card = CARD_AND;
                    FN_OR:    dec.card = CARD_OR;
                    FN_XOR:   dec.card = CARD_XOR;
                    FN_MOVZ:  dec.card = CARD_MOVZ;
                    FN_SIL:   dec.card = CARD_SIL;
                    FN_CMP:   dec.card = CARD_CMP;
                    default:  dec.iclass = CLS_ILL;
                endcase
            end
            OP_LW: begin
                dec.iclass  = CLS_LW;
                dec.card    = CARD_ADD;
                dec.src_imm = 1'b1;
            end
            OP_SW: begin
                dec.iclass  = CLS_SW;
                dec.card    = CARD_ADD;
                dec.src_imm = 1'b1;
            end
            OP_J:    dec.iclass = CLS_J;
            default: dec.iclass = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: IF/ID/EX/MEM/WB sequencing, memory handshake
// timeouts, sticky fault via HALT, and a retired-instruction counter.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_WAIT_MAX = 15,
    parameter int unsigned DMEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        alu_wen,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_en,
    output logic [4:0]  alu_card,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic        rf_wdata_sel,
    output logic        fault,
    output logic [2:0]  state_dbg,
    output logic [31:31-31] retired
);

    localparam int unsigned WAIT_MAX = (IMEM_WAIT_MAX > DMEM_WAIT_MAX) ? IMEM_WAIT_MAX : DMEM_WAIT_MAX;
    localparam int unsigned CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] IMEM_LIM = CW'(IMEM_WAIT_MAX);
    localparam logic [CW-1:0] DMEM_LIM = CW'(DMEM_WAIT_MAX);

    state_t        state, state_next;
    logic [5:0]    ir_op, ir_fn;
    decode_t       dec, dec_q;
    logic [CW-1:0] wait_cnt;
    logic          retire;

    // The datapath owns the full IR; only the decode fields are kept here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    cpu_decode u_decode (
        .op    (ir_op),
        .funct (ir_fn),
        .dec   (dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            ir_op    <= '0;
            ir_fn    <= '0;
            dec_q    <= '{card: CARD_NONE, iclass: CLS_ILL, src_imm: 1'b0};
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_next;
            if (ir_we) begin
                ir_op <= instr[31:26];
                ir_fn <= instr[5:0];
            end
            if (state == ST_ID)
                dec_q <= dec;
            // Counts unacknowledged cycles; any state change clears it for the next wait.
            if ((state_next == state) && ((state == ST_IF) || (state == ST_MEM)))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        state_next   = state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 1'b0;
        rf_wdata_sel = 1'b0;
        retire       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_IF;
            ST_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = ST_ID;
                end else if (wait_cnt == IMEM_LIM) begin
                    state_next = ST_HALT;
                end
            end
            ST_ID: begin
                case (dec.iclass)
                    CLS_R, CLS_LW, CLS_SW: state_next = ST_EX;
                    CLS_J: begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_SEL_JUMP;
                        retire     = 1'b1;
                        state_next = start ? ST_IF : ST_IDLE;
                    end
                    default: state_next = ST_HALT;
                endcase
            end
            ST_EX: begin
                alu_en     = 1'b1;
                state_next = (dec_q.iclass == CLS_R) ? ST_WB : ST_MEM;
            end
            ST_MEM: begin
                alu_en   = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (dec_q.iclass == CLS_SW);
                if (dmem_ack) begin
                    if (dec_q.iclass == CLS_SW) begin
                        retire     = 1'b1;
                        state_next = ST_IF;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_cnt == DMEM_LIM) begin
                    state_next = ST_HALT;
                end
            end
            ST_WB: begin
                alu_en       = 1'b1;
                rf_we        = (dec_q.iclass == CLS_LW) ? 1'b1 : alu_wen;
                rf_wsel      = (dec_q.iclass == CLS_LW);
                rf_wdata_sel = (dec_q.iclass == CLS_LW);
                retire       = 1'b1;
                state_next   = start ? ST_IF : ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    assign alu_card    = alu_en ? dec_q.card : CARD_NONE;
    assign alu_src_imm = alu_en & dec_q.src_imm;
    assign fault       = (state == ST_HALT);
    assign state_dbg   = state;

endmodule
